simplerisc_pc_unit: RTL and testbench

- Program-counter and branch-resolution stage of the single-cycle SimpleRISC core.
- Consumes the E/GT flags held in the negedge flag flops (written by cmp in cycle N, read here in cycle N+1). Produces the fetch address for instruction memory.
- Owns the run/stall/halt control of the core.
- Has an optional hardware return-address stack for call/ret.

---
 rtl/simplerisc_pc_unit.sv | 191 +++++++++++++++++++
 tb/tb_simplerisc_pc_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simplerisc_pc_unit.sv
// simplerisc_pc_unit
//   Program counter and branch resolution for the single-cycle SimpleRISC
//   core. It also owns the run/stall/halt control of the core.
//
// Optional build macro: SIMPLERISC_PC_RAS_EN
//   When defined, a circular return-address stack of RAS_DEPTH entries
//   supplies ret targets. When undefined, ret always jumps to ra_value and
//   the stack status outputs are held at 0.
//
// Ports
//   clk, reset        posedge clock, asynchronous active-high reset
//   flag_e, flag_gt   flags from the negedge flag flops, stable all cycle
//   is_beq, is_bgt    conditional branch decodes
//   is_ub             unconditional branch (b, call, ret)
//   is_call, is_ret   call / ret decodes (ret wins if both are set)
//   branch_target     decoded target; the low two bits are dropped
//   ra_value          ra register value (ret target without a stack hit)
//   stall             hold the PC this cycle
//   halt_req          current instruction is hlt
//   resume            leave HALT and fetch from pc+4
//   pc                registered fetch address
//   pc_plus4          pc+4 modulo 2^WIDTH, also the call link value
//   branch_taken      the current instruction redirects the PC
//   halted            1 while in HALT
//   ras_overflow      sticky, set by a push onto a full stack
//   ras_underflow     one-cycle pulse after a ret that found the stack empty
//
// Control handshake: there is no valid/ready pairing here. Each input
// describes the instruction at pc for the current cycle, and every state
// change takes effect on the next rising clock edge.
module simplerisc_pc_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_e,
  input  logic             flag_gt,
  input  logic             is_beq,
  input  logic             is_bgt,
  input  logic             is_ub,
  input  logic             is_call,
  input  logic             is_ret,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] ra_value,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             branch_taken,
  output logic             halted,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             taken_raw;
  logic             eff_run;
  logic             go;
  logic [WIDTH-1:0] ret_addr;

  assign taken_raw = is_ub | (is_beq & flag_e) | (is_bgt & flag_gt);

  // A STALL cycle whose stall input has dropped behaves as a RUN cycle, so
  // the held instruction executes in the very cycle the stall is released.
  assign eff_run = (state_q == ST_RUN) | ((state_q == ST_STALL) & ~stall);

  // The instruction at pc actually executes this cycle.
  assign go = eff_run & ~halt_req & ~stall;

  assign pc_plus4     = pc_q + WIDTH'(4);
  assign branch_taken = go & taken_raw;
  assign pc           = pc_q;
  assign halted       = (state_q == ST_HALT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (state_q == ST_HALT) begin
      if (resume) begin
        pc_d    = pc_plus4;
        state_d = ST_RUN;
      end
    end else if (eff_run) begin
      if (halt_req) begin
        state_d = ST_HALT;
      end else if (stall) begin
        state_d = ST_STALL;
      end else begin
        state_d = ST_RUN;
        if (is_ret) begin
          pc_d = ret_addr;
        end else if (taken_raw) begin
          pc_d = {branch_target[WIDTH-1:2], 2'b00};
        end else begin
          pc_d = pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef SIMPLERISC_PC_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr_q, ras_ptr_d;
  logic [CW-1:0]    ras_cnt_q, ras_cnt_d;
  logic             ras_ovf_q, ras_ovf_d;
  logic             ras_unf_q, ras_unf_d;
  logic             ras_empty;
  logic             ras_full;
  logic             do_push;
  logic             do_pop;

  // ras_ptr_q points at the next free slot; the top lives one below it.
  // A push onto a full stack lands on the oldest entry because the pointer
  // has wrapped round to it.
  assign ras_empty = (ras_cnt_q == '0);
  assign ras_full  = (ras_cnt_q == CW'(RAS_DEPTH));
  assign do_push   = go & is_call & taken_raw & ~is_ret;
  assign do_pop    = go & is_ret & ~ras_empty;
  assign ret_addr  = ras_empty ? ra_value : ras_mem_q[ras_ptr_q - PW'(1)];

  always_comb begin
    ras_mem_d = ras_mem_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_ovf_d = ras_ovf_q;
    ras_unf_d = go & is_ret & ras_empty;
    if (do_push) begin
      ras_mem_d[ras_ptr_q] = pc_plus4;
      ras_ptr_d            = ras_ptr_q + PW'(1);
      if (ras_full) begin
        ras_ovf_d = 1'b1;
      end else begin
        ras_cnt_d = ras_cnt_q + CW'(1);
      end
    end else if (do_pop) begin
      ras_ptr_d = ras_ptr_q - PW'(1);
      ras_cnt_d = ras_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_mem_q[i] <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
    end else begin
      ras_mem_q <= ras_mem_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
      ras_ovf_q <= ras_ovf_d;
      ras_unf_q <= ras_unf_d;
    end
  end

  assign ras_overflow  = ras_ovf_q;
  assign ras_underflow = ras_unf_q;
`else
  logic unused_call;
  assign unused_call   = is_call;
  assign ret_addr      = ra_value;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_simplerisc_pc_unit.sv
// Testbench for simplerisc_pc_unit (default parameters, WIDTH=32).
// A behavioural model tracks pc, run mode and the return-address stack
// (as a queue) from the instruction-level rules; directed scenarios check
// the documented examples and a randomized run compares every cycle.
module tb_simplerisc_pc_unit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         flag_e, flag_gt, is_beq, is_bgt, is_ub, is_call, is_ret;
  logic [W-1:0] branch_target, ra_value;
  logic         stall, halt_req, resume;
  logic [W-1:0] pc, pc_plus4;
  logic         branch_taken, halted, ras_overflow, ras_underflow;

  simplerisc_pc_unit dut (
    .clk(clk), .reset(reset),
    .flag_e(flag_e), .flag_gt(flag_gt),
    .is_beq(is_beq), .is_bgt(is_bgt), .is_ub(is_ub),
    .is_call(is_call), .is_ret(is_ret),
    .branch_target(branch_target), .ra_value(ra_value),
    .stall(stall), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus4(pc_plus4), .branch_taken(branch_taken),
    .halted(halted), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  // m_mode: 0 = running, 1 = stalled, 2 = halted
  logic [W-1:0] m_pc;
  int           m_mode;
  logic         m_ovf, m_unf;
  logic [W-1:0] ras_model_q[$];
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_pc = '0; m_mode = 0; m_ovf = 1'b0; m_unf = 1'b0;
    ras_model_q.delete();
  endtask

  function automatic logic model_taken();
    logic t;
    t = is_ub | (is_beq & flag_e) | (is_bgt & flag_gt);
    return (m_mode != 2) && !halt_req && !stall && t;
  endfunction

  task automatic model_step();
    logic t;
    t = is_ub | (is_beq & flag_e) | (is_bgt & flag_gt);
    m_unf = 1'b0;
    if (m_mode == 2) begin
      if (resume) begin m_pc = m_pc + 32'd4; m_mode = 0; end
    end else if (m_mode == 0 || !stall) begin
      if (halt_req) m_mode = 2;
      else if (stall) m_mode = 1;
      else begin
        m_mode = 0;
        if (is_ret) begin
`ifdef SIMPLERISC_PC_RAS_EN
          if (ras_model_q.size() > 0) m_pc = ras_model_q.pop_back();
          else begin m_pc = ra_value; m_unf = 1'b1; end
`else
          m_pc = ra_value;
`endif
        end else if (t) begin
`ifdef SIMPLERISC_PC_RAS_EN
          if (is_call) begin
            ras_model_q.push_back(m_pc + 32'd4);
            if (ras_model_q.size() > 4) begin
              ras_model_q.delete(0);
              m_ovf = 1'b1;
            end
          end
`endif
          m_pc = branch_target & ~32'd3;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    flag_e = 0; flag_gt = 0; is_beq = 0; is_bgt = 0; is_ub = 0;
    is_call = 0; is_ret = 0; branch_target = '0; ra_value = '0;
    stall = 0; halt_req = 0; resume = 0;
  endtask

  // Advance one clock with the current inputs; leaves time at posedge+1.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    tests_run++;
    if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %b expected 0", halted); end
    tests_run++;
    if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ras_flags: got %b%b expected 00", ras_overflow, ras_underflow);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    logic [W-1:0] e;
    clear_inputs();
    exp_q.delete();
    exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (pc !== e || pc !== m_pc) begin tests_failed++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, e); end
    end
    // asynchronous reset in the middle of a cycle
    #3 reset = 1'b1;
    #1;
    tests_run++;
    if (pc !== 32'h0) begin tests_failed++; $display("FAIL async_reset_pc: got %h expected %h", pc, 32'h0); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_branch();
    clear_inputs();
    flag_e = 1; is_beq = 1; branch_target = 32'h103;
    #1;
    tests_run++;
    if (branch_taken !== 1'b1) begin tests_failed++; $display("FAIL beq_taken: got %b expected 1", branch_taken); end
    tick();
    tests_run++;
    if (pc !== 32'h100) begin tests_failed++; $display("FAIL beq_target: got %h expected %h", pc, 32'h100); end
    flag_e = 0;
    #1;
    tests_run++;
    if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL beq_not_taken: got %b expected 0", branch_taken); end
    tick();
    tests_run++;
    if (pc !== 32'h104) begin tests_failed++; $display("FAIL beq_fallthrough: got %h expected %h", pc, 32'h104); end
    clear_inputs();
  endtask

  task automatic test_stall();
    logic [W-1:0] held;
    clear_inputs();
    held = pc;
    is_bgt = 1; flag_gt = 1; branch_target = 32'h40; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL stall_taken[%0d]: got %b expected 0", i, branch_taken); end
      tick();
      tests_run++;
      if (pc !== held) begin tests_failed++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, pc, held); end
    end
    stall = 0;
    #1;
    tests_run++;
    if (branch_taken !== 1'b1) begin tests_failed++; $display("FAIL stall_release_taken: got %b expected 1", branch_taken); end
    tick();
    tests_run++;
    if (pc !== 32'h40) begin tests_failed++; $display("FAIL stall_release_pc: got %h expected %h", pc, 32'h40); end
    clear_inputs();
  endtask

  task automatic test_halt();
    clear_inputs();
    is_ub = 1; branch_target = 32'h20;
    tick();
    clear_inputs();
    halt_req = 1; is_ub = 1; branch_target = 32'h300;
    tick();
    tests_run++;
    if (halted !== 1'b1 || pc !== 32'h20) begin
      tests_failed++; $display("FAIL halt_enter: got halted=%b pc=%h expected halted=1 pc=%h", halted, pc, 32'h20);
    end
    halt_req = 0;
    for (int i = 0; i < 10; i++) begin
      is_ub = 1; branch_target = $urandom(); stall = 1'($urandom_range(0, 1));
      #1;
      tests_run++;
      if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL halt_taken[%0d]: got %b expected 0", i, branch_taken); end
      tick();
      tests_run++;
      if (pc !== 32'h20 || halted !== 1'b1) begin
        tests_failed++; $display("FAIL halt_hold[%0d]: got pc=%h halted=%b expected pc=%h halted=1", i, pc, halted, 32'h20);
      end
    end
    clear_inputs();
    resume = 1;
    tick();
    tests_run++;
    if (pc !== 32'h24 || halted !== 1'b0) begin
      tests_failed++; $display("FAIL halt_resume: got pc=%h halted=%b expected pc=%h halted=0", pc, halted, 32'h24);
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    clear_inputs();
    is_ub = 1; branch_target = 32'hFFFF_FFFF;
    tick();
    tests_run++;
    if (pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_setup: got %h expected %h", pc, 32'hFFFF_FFFC); end
    clear_inputs();
    #1;
    tests_run++;
    if (pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_plus4: got %h expected %h", pc_plus4, 32'h0); end
    tick();
    tests_run++;
    if (pc !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
  endtask

  task automatic test_ras();
    logic [W-1:0] rets [4];
    do_reset();
`ifdef SIMPLERISC_PC_RAS_EN
    rets[0] = 32'h44; rets[1] = 32'h34; rets[2] = 32'h24; rets[3] = 32'h14;
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      is_ub = 1; is_call = 1; branch_target = 32'((i + 1) * 16);
      tick();
      tests_run++;
      if (ras_overflow !== (i == 4)) begin
        tests_failed++; $display("FAIL ras_ovf_call%0d: got %b expected %b", i, ras_overflow, (i == 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      is_ub = 1; is_ret = 1; ra_value = 32'hDEAD_0000;
      tick();
      tests_run++;
      if (pc !== rets[i]) begin tests_failed++; $display("FAIL ras_ret%0d: got %h expected %h", i, pc, rets[i]); end
    end
    clear_inputs();
    is_ub = 1; is_ret = 1; ra_value = 32'h200;
    tick();
    tests_run++;
    if (pc !== 32'h200 || ras_underflow !== 1'b1) begin
      tests_failed++; $display("FAIL ras_underflow: got pc=%h unf=%b expected pc=%h unf=1", pc, ras_underflow, 32'h200);
    end
    clear_inputs();
    tick();
    tests_run++;
    if (ras_underflow !== 1'b0 || ras_overflow !== 1'b1) begin
      tests_failed++; $display("FAIL ras_flags_after: got unf=%b ovf=%b expected unf=0 ovf=1", ras_underflow, ras_overflow);
    end
`else
    rets[0] = 32'h200; rets[1] = 32'h0; rets[2] = 32'h0; rets[3] = 32'h0;
    clear_inputs();
    is_ub = 1; is_call = 1; branch_target = 32'h10;
    tick();
    clear_inputs();
    is_ub = 1; is_ret = 1; ra_value = rets[0];
    tick();
    tests_run++;
    if (pc !== 32'h200 || ras_underflow !== 1'b0 || ras_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL ret_ra_value: got pc=%h unf=%b ovf=%b expected pc=%h 0 0", pc, ras_underflow, ras_overflow, 32'h200);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      flag_e        = 1'($urandom_range(0, 1));
      flag_gt       = 1'($urandom_range(0, 1));
      is_beq        = ($urandom_range(0, 3) == 0);
      is_bgt        = ($urandom_range(0, 3) == 0);
      is_call       = ($urandom_range(0, 5) == 0);
      is_ret        = ($urandom_range(0, 7) == 0);
      is_ub         = is_call | is_ret | ($urandom_range(0, 7) == 0);
      branch_target = $urandom();
      ra_value      = $urandom();
      stall         = ($urandom_range(0, 3) == 0);
      halt_req      = ($urandom_range(0, 19) == 0);
      resume        = ($urandom_range(0, 3) == 0);
      #1;
      tests_run++;
      if (branch_taken !== model_taken() || pc_plus4 !== m_pc + 32'd4) begin
        tests_failed++;
        $display("FAIL rand_comb[%0d]: got bt=%b p4=%h expected bt=%b p4=%h", i, branch_taken, pc_plus4, model_taken(), m_pc + 32'd4);
      end
      tick();
      tests_run++;
      if (pc !== m_pc || halted !== (m_mode == 2) || ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
        tests_failed++;
        $display("FAIL rand_state[%0d]: got pc=%h h=%b o=%b u=%b expected pc=%h h=%b o=%b u=%b",
                 i, pc, halted, ras_overflow, ras_underflow, m_pc, (m_mode == 2), m_ovf, m_unf);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt();
    test_wrap();
    test_ras();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
